// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shared miss handler between the I-cache, the D-cache and
// main memory. It grants one request at a time (store > D miss > I miss),
// reads a whole block as BLOCK_WORDS word reads, streams the returned words
// into the owning cache's data array, and then pulses that cache's tag write.
//
// Optional feature macro: CACHE_FILL_WRITE_THROUGH_EN
//   defined   : D-cache write-through stores are issued through a WRITE state
//   undefined : d_wr_* inputs are ignored; d_wr_ack, mem_wr and mem_wdata are 0
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_miss / i_miss_addr             I-cache miss request and byte address
//   d_miss / d_miss_addr             D-cache miss request and byte address
//   d_wr_req/d_wr_addr/d_wr_data     D-cache store request
//   d_wr_ack                         pulse when the store is issued to memory
//   mem_en/mem_wr/mem_addr/mem_wdata memory command (registered)
//   mem_rdata/mem_rvalid             in-order read return
//   fill_data/fill_word              word and word index for the data array
//   i_data_we/d_data_we              data array write strobes
//   i_tag_we/d_tag_we                tag/valid write pulses
//   fill_addr                        latched block base address
module cache_fill_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    input  logic                           d_wr_req,
    input  logic [ADDR_W-1:0]              d_wr_addr,
    input  logic [DATA_W-1:0]              d_wr_data,
    output logic                           d_wr_ack,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_rvalid,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_data_we,
    output logic                           d_data_we,
    output logic                           i_tag_we,
    output logic                           d_tag_we,
    output logic [ADDR_W-1:0]              fill_addr
);

    localparam int unsigned WORD_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W  = WORD_W + 1;
    // Byte offset bits within one block (two bytes per word).
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);

`ifdef CACHE_FILL_WRITE_THROUGH_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAG   = 2'd2,
        WRITE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAG   = 2'd2
    } state_t;
`endif

    state_t             state, state_nx;
    logic               owner_d, owner_d_nx;
    logic [CNT_W-1:0]   issue_cnt, issue_nx;
    logic [CNT_W-1:0]   ret_cnt, ret_nx;
    logic               mem_en_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic [DATA_W-1:0]  fill_data_nx;
    logic [WORD_W-1:0]  fill_word_nx;
    logic               i_data_we_nx, d_data_we_nx;
    logic               i_tag_we_nx, d_tag_we_nx;
    logic [ADDR_W-1:0]  fill_addr_nx;
    logic [ADDR_W-1:0]  miss_base_c;

`ifdef CACHE_FILL_WRITE_THROUGH_EN
    logic               mem_wr_nx;
    logic [DATA_W-1:0]  mem_wdata_nx;
    logic               d_wr_ack_nx;
`endif

    // Aligned block base of the miss that would win arbitration (D over I).
    assign miss_base_c = (d_miss ? d_miss_addr : i_miss_addr) & ~OFF_MASK;

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        owner_d_nx   = owner_d;
        issue_nx     = issue_cnt;
        ret_nx       = ret_cnt;
        mem_en_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        fill_data_nx = fill_data;
        fill_word_nx = fill_word;
        i_data_we_nx = 1'b0;
        d_data_we_nx = 1'b0;
        i_tag_we_nx  = 1'b0;
        d_tag_we_nx  = 1'b0;
        fill_addr_nx = fill_addr;
`ifdef CACHE_FILL_WRITE_THROUGH_EN
        mem_wr_nx    = 1'b0;
        mem_wdata_nx = mem_wdata;
        d_wr_ack_nx  = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef CACHE_FILL_WRITE_THROUGH_EN
                if (d_wr_req) begin
                    state_nx     = WRITE;
                    mem_en_nx    = 1'b1;
                    mem_wr_nx    = 1'b1;
                    mem_addr_nx  = d_wr_addr;
                    mem_wdata_nx = d_wr_data;
                    d_wr_ack_nx  = 1'b1;
                end else
`endif
                if (d_miss || i_miss) begin
                    state_nx     = FILL;
                    owner_d_nx   = d_miss;
                    fill_addr_nx = miss_base_c;
                    // Read of word 0 is issued on the grant edge itself, so
                    // the issue count leaves the grant already at one.
                    mem_en_nx    = 1'b1;
                    mem_addr_nx  = miss_base_c;
                    issue_nx     = CNT_W'(1);
                    ret_nx       = '0;
                end
            end
            FILL: begin
                if (issue_cnt < CNT_FULL) begin
                    mem_en_nx   = 1'b1;
                    mem_addr_nx = fill_addr + ADDR_W'({issue_cnt[WORD_W-1:0], 1'b0});
                    issue_nx    = issue_cnt + CNT_W'(1);
                end
                // ret_cnt reaches full in the cycle the last data write is
                // visible; the tag write follows directly.
                if (ret_cnt == CNT_FULL) begin
                    state_nx    = TAG;
                    i_tag_we_nx = ~owner_d;
                    d_tag_we_nx = owner_d;
                end else if (mem_rvalid) begin
                    fill_data_nx = mem_rdata;
                    fill_word_nx = WORD_W'(ret_cnt);
                    i_data_we_nx = ~owner_d;
                    d_data_we_nx = owner_d;
                    ret_nx       = ret_cnt + CNT_W'(1);
                end
            end
            TAG: begin
                state_nx = IDLE;
            end
`ifdef CACHE_FILL_WRITE_THROUGH_EN
            WRITE: begin
                state_nx = IDLE;
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            fill_data <= '0;
            fill_word <= '0;
            i_data_we <= 1'b0;
            d_data_we <= 1'b0;
            i_tag_we  <= 1'b0;
            d_tag_we  <= 1'b0;
            fill_addr <= '0;
        end else begin
            state     <= state_nx;
            owner_d   <= owner_d_nx;
            issue_cnt <= issue_nx;
            ret_cnt   <= ret_nx;
            mem_en    <= mem_en_nx;
            mem_addr  <= mem_addr_nx;
            fill_data <= fill_data_nx;
            fill_word <= fill_word_nx;
            i_data_we <= i_data_we_nx;
            d_data_we <= d_data_we_nx;
            i_tag_we  <= i_tag_we_nx;
            d_tag_we  <= d_tag_we_nx;
            fill_addr <= fill_addr_nx;
        end
    end

`ifdef CACHE_FILL_WRITE_THROUGH_EN
    // Store command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            d_wr_ack  <= 1'b0;
        end else begin
            mem_wr    <= mem_wr_nx;
            mem_wdata <= mem_wdata_nx;
            d_wr_ack  <= d_wr_ack_nx;
        end
    end
`else
    // Store path absent: outputs tied off, store inputs deliberately unused.
    logic unused_store;
    assign unused_store = ^{d_wr_req, d_wr_addr, d_wr_data};
    assign mem_wr       = 1'b0;
    assign mem_wdata    = '0;
    assign d_wr_ack     = 1'b0;
`endif

endmodule
